min_max_job_scheduler: RTL

Shares one 16-entry unsigned 8-bit min/max finder engine among NREQ requesters using round-robin arbitration. The block performs four steps per job: grant, stream 16 elements into the engine's array write port, pulse engine Start, then wait for engine Done (with watchdog). It returns Max/Min to the granted requester as a one-cycle response. It sits between the requester fabric and a single finder instance.

---
 rtl/min_max_job_scheduler_pkg.sv | 16 +
 rtl/min_max_job_scheduler_if.sv | 23 ++
 rtl/min_max_job_scheduler_rr_arbiter.sv | 30 +++
 rtl/min_max_job_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/min_max_job_scheduler_pkg.sv
// rtl/min_max_job_scheduler_pkg.sv - shared constants and state encodings for the min/max job scheduler
package min_max_job_scheduler_pkg;

  localparam int ELEM_W = 8;
  localparam int NELEM  = 16;
  localparam int CNT_W  = $clog2(NELEM);

  typedef logic [4:0] state_t;

  localparam state_t ST_IDLE  = 5'b00001;
  localparam state_t ST_LOAD  = 5'b00010;
  localparam state_t ST_START = 5'b00100;
  localparam state_t ST_WAIT  = 5'b01000;
  localparam state_t ST_RESP  = 5'b10000;

endpackage

// File: rtl/min_max_job_scheduler_if.sv
// rtl/min_max_job_scheduler_if.sv - bus between the scheduler and the shared min/max finder engine
interface min_max_job_scheduler_if;
  import min_max_job_scheduler_pkg::*;

  logic              Eng_WrEn;
  logic [CNT_W-1:0]  Eng_WrAddr;
  logic [ELEM_W-1:0] Eng_WrData;
  logic              Eng_Start;
  logic              Eng_Done;
  logic [ELEM_W-1:0] Eng_Max;
  logic [ELEM_W-1:0] Eng_Min;

  modport master (
    output Eng_WrEn, Eng_WrAddr, Eng_WrData, Eng_Start,
    input  Eng_Done, Eng_Max, Eng_Min
  );

  modport slave (
    input  Eng_WrEn, Eng_WrAddr, Eng_WrData, Eng_Start,
    output Eng_Done, Eng_Max, Eng_Min
  );

endinterface

// File: rtl/min_max_job_scheduler_rr_arbiter.sv
// rtl/min_max_job_scheduler_rr_arbiter.sv - combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  Req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && Req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/min_max_job_scheduler.sv
// rtl/min_max_job_scheduler.sv - round-robin sharing of one 16-entry min/max finder among NREQ requesters
module min_max_job_scheduler
  import min_max_job_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NREQ-1:0]     Req,
  output logic [NREQ-1:0]     Gnt,
  input  logic [ELEM_W-1:0]   Din,
  input  logic                Din_Valid,
  output logic                Busy,
  output logic [NREQ-1:0]     Rsp_Valid,
  output logic [ELEM_W-1:0]   Rsp_Max,
  output logic [ELEM_W-1:0]   Rsp_Min,
  output logic                Rsp_Err,
  min_max_job_scheduler_if.master eng
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WD_W-1:0]  wd;
  logic [WD_W-1:0]  wd_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .Req (Req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign wd_next = wd + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      Gnt     <= '0;
      gidx    <= '0;
      cnt     <= '0;
      wd      <= '0;
      ptr     <= '0;
      Rsp_Max <= '0;
      Rsp_Min <= '0;
      Rsp_Err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|Req) begin
            Gnt   <= arb_gnt;
            gidx  <= arb_idx;
            cnt   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (Din_Valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(NELEM - 1)) state <= ST_START;
          end
        end
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          wd <= wd_next;
          // Done beats a simultaneous expiry; expiry lands RESP TIMEOUT cycles after Start
          if (eng.Eng_Done) begin
            Rsp_Max <= eng.Eng_Max;
            Rsp_Min <= eng.Eng_Min;
            Rsp_Err <= 1'b0;
            state   <= ST_RESP;
          end else if (wd_next == WD_W'(TIMEOUT - 1)) begin
            Rsp_Max <= '0;
            Rsp_Min <= '0;
            Rsp_Err <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          ptr   <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
          Gnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          Gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy           = (state != ST_IDLE);
  assign Rsp_Valid      = (state == ST_RESP) ? Gnt : '0;
  assign eng.Eng_Start  = (state == ST_START);
  assign eng.Eng_WrEn   = (state == ST_LOAD) && Din_Valid;
  assign eng.Eng_WrAddr = cnt;
  assign eng.Eng_WrData = Din;

endmodule
